// File: rtl/usb_uart_out_ep.sv
// USB OUT endpoint to UART byte-stream bridge.
// Reads host bytes from the OUT endpoint data interface into a small holding
// FIFO and presents them to the UART pipeline with a valid/ready handshake.
// Reads are throttled so that FIFO entries plus the byte still in flight
// from the endpoint never exceed FIFO_DEPTH.
module usb_uart_out_ep #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       out_ep_req,
  input  logic       out_ep_grant,
  input  logic       out_ep_data_avail,
  input  logic       out_ep_setup,
  output logic       out_ep_data_get,
  input  logic [7:0] out_ep_data,
  output logic       out_ep_stall,
  input  logic       out_ep_acked,
  output logic [7:0] uart_out_data,
  output logic       uart_out_valid,
  input  logic       uart_out_ready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_GRANT = 2'd1,
    S_TRANSFER   = 2'd2,
    S_DRAIN      = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_inflight;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_mem [FIFO_DEPTH];

  logic [CW:0]   w_level;
  logic          w_room_idle;
  logic          w_room;
  logic          w_req;
  logic          w_get;
  logic          w_push;
  logic          w_pop;
  logic          w_unused;

  // SETUP flag and ACK status carry no meaning for this bridge.
  assign w_unused = out_ep_setup ^ out_ep_acked;

  // Occupancy including the byte already requested but not yet landed.
  assign w_level     = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_room_idle = {1'b0, r_count} < DEPTH_L;
  assign w_room      = w_level < DEPTH_L;

  assign w_push = r_inflight;
  assign w_pop  = (r_count != '0) && uart_out_ready;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (out_ep_data_avail && w_room_idle) w_state_nxt = S_WAIT_GRANT;
      end
      S_WAIT_GRANT: begin
        if (out_ep_grant)            w_state_nxt = S_TRANSFER;
        else if (!out_ep_data_avail) w_state_nxt = S_IDLE;
      end
      S_TRANSFER: begin
        if (!out_ep_data_avail || !w_room) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_inflight) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Endpoint request and read strobe.
  always_comb begin
    w_req = 1'b0;
    w_get = 1'b0;
    case (r_state)
      S_IDLE:       w_req = out_ep_data_avail && w_room_idle;
      S_WAIT_GRANT: w_req = 1'b1;
      S_TRANSFER: begin
        w_req = 1'b1;
        w_get = out_ep_grant && out_ep_data_avail && w_room;
      end
      S_DRAIN:      w_req = r_inflight;
      default: begin
        w_req = 1'b0;
        w_get = 1'b0;
      end
    endcase
  end

  // Idle may request combinationally from data_avail, so mask with reset.
  assign out_ep_req      = w_req & reset;
  assign out_ep_data_get = w_get & reset;
  assign out_ep_stall    = 1'b0;

  // In-flight flag, FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_get;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // FIFO storage; endpoint data is captured the cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= out_ep_data;
  end

  assign uart_out_data  = r_mem[r_rd_ptr];
  assign uart_out_valid = (r_count != '0);

endmodule

// File: tb/tb_usb_uart_out_ep.sv
// Self-checking bench for usb_uart_out_ep: endpoint and grant models drive
// the DUT; a byte-level scoreboard predicts when each fetched byte becomes
// visible at the UART side and in which order it must leave.
module tb_usb_uart_out_ep;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       out_ep_req;
  logic       out_ep_grant;
  logic       out_ep_data_avail;
  logic       out_ep_setup;
  logic       out_ep_data_get;
  logic [7:0] out_ep_data;
  logic       out_ep_stall;
  logic       out_ep_acked;
  logic [7:0] uart_out_data;
  logic       uart_out_valid;
  logic       uart_out_ready;

  always #5 clk = ~clk;

  usb_uart_out_ep #(.FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .out_ep_req        (out_ep_req),
    .out_ep_grant      (out_ep_grant),
    .out_ep_data_avail (out_ep_data_avail),
    .out_ep_setup      (out_ep_setup),
    .out_ep_data_get   (out_ep_data_get),
    .out_ep_data       (out_ep_data),
    .out_ep_stall      (out_ep_stall),
    .out_ep_acked      (out_ep_acked),
    .uart_out_data     (uart_out_data),
    .uart_out_valid    (uart_out_valid),
    .uart_out_ready    (uart_out_ready)
  );

  // A fetched byte and the cycle from which it must be visible downstream.
  typedef struct {
    logic [7:0] data;
    int         due;
  } land_t;

  logic [7:0] ep_q[$];    // unread host bytes held by the endpoint
  land_t      land_q[$];  // fetched but not yet accepted downstream

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gets_total = 0;
  int accepted = 0;
  int gdelay = 1;
  int gcnt = 0;
  int ready_mode = 1;     // 0: ready low, 1: ready high, 2: random
  int first_get_cyc = -1;
  int last_get_cyc = -1;
  int first_req_cyc = -1;
  logic req_dropped = 1'b0;

  logic       req_s;
  logic       get_s;
  logic       valid_s;
  logic [7:0] data_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_marks();
    first_get_cyc = -1;
    last_get_cyc  = -1;
    first_req_cyc = -1;
    req_dropped   = 1'b0;
  endtask

  // One clock: sample and check at the falling edge, update models and
  // drive new inputs just after the rising edge.
  task automatic cycle();
    logic       exp_valid;
    logic [7:0] b;
    @(negedge clk);
    cyc++;
    req_s   = out_ep_req;
    get_s   = out_ep_data_get;
    valid_s = uart_out_valid;
    data_s  = uart_out_data;
    check("stall", out_ep_stall, 0);
    if (!reset) begin
      check("rst_req", req_s, 0);
      check("rst_get", get_s, 0);
    end
    if (get_s) begin
      check("get_qual", {out_ep_grant, out_ep_data_avail}, 2'b11);
      gets_total++;
      if (first_get_cyc < 0) first_get_cyc = cyc;
      last_get_cyc = cyc;
    end
    if (req_s && first_req_cyc < 0) first_req_cyc = cyc;
    if (first_req_cyc >= 0 && first_get_cyc < 0 && !req_s) req_dropped = 1'b1;
    exp_valid = (land_q.size() != 0) && (land_q[0].due <= cyc);
    check("valid", valid_s, exp_valid);
    if (exp_valid) begin
      check("data", data_s, land_q[0].data);
      if (uart_out_ready) begin
        void'(land_q.pop_front());
        accepted++;
      end
    end
    @(posedge clk);
    #1;
    if (get_s) begin
      b = (ep_q.size() != 0) ? ep_q.pop_front() : 8'h00;
      land_q.push_back('{b, cyc + 2});
      check("occupancy", land_q.size() <= DEPTH, 1);
      out_ep_data = b;
    end else begin
      out_ep_data = 8'($urandom);
    end
    out_ep_data_avail = (ep_q.size() != 0);
    gcnt = req_s ? gcnt + 1 : 0;
    out_ep_grant = req_s && (gcnt >= gdelay);
    out_ep_setup = 1'($urandom_range(0, 1));
    out_ep_acked = 1'($urandom_range(0, 1));
    uart_out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  endtask

  task automatic load(input int n, input bit rnd, input logic [7:0] base);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = rnd ? 8'($urandom) : base + 8'(i);
      ep_q.push_back(v);
    end
    out_ep_data_avail = (ep_q.size() != 0);
  endtask

  task automatic drain(input string tag, input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      cycle();
      if (ep_q.size() == 0 && land_q.size() == 0 && !req_s) done = 1'b1;
    end
    check(tag, done, 1);
  endtask

  initial begin
    int g0;
    int a0;
    bit reached;

    // Reset state, with the endpoint offering data and grant.
    reset = 1'b0;
    out_ep_grant = 1'b1;
    out_ep_data_avail = 1'b1;
    out_ep_setup = 1'b0;
    out_ep_data = 8'h00;
    out_ep_acked = 1'b0;
    uart_out_ready = 1'b1;
    #3;
    check("reset_req", out_ep_req, 0);
    check("reset_get", out_ep_data_get, 0);
    check("reset_valid", uart_out_valid, 0);
    check("reset_stall", out_ep_stall, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_hold", out_ep_req, 0);
    check("reset_valid_hold", uart_out_valid, 0);
    out_ep_grant = 1'b0;
    out_ep_data_avail = 1'b0;
    reset = 1'b1;
    repeat (2) cycle();

    // Single byte.
    clear_marks();
    gdelay = 1; ready_mode = 1; uart_out_ready = 1'b1;
    g0 = gets_total; a0 = accepted;
    load(1, 1'b0, 8'h5A);
    drain("single_drain", 40);
    check("single_gets", gets_total - g0, 1);
    check("single_accepted", accepted - a0, 1);

    // Eight-byte burst at full rate.
    clear_marks();
    g0 = gets_total; a0 = accepted;
    load(8, 1'b0, 8'h00);
    drain("burst_drain", 60);
    check("burst_gets", gets_total - g0, 8);
    check("burst_consec", last_get_cyc - first_get_cyc, 7);
    check("burst_accepted", accepted - a0, 8);

    // Backpressure: downstream stalled while eight bytes are available.
    clear_marks();
    ready_mode = 0; uart_out_ready = 1'b0;
    g0 = gets_total; a0 = accepted;
    load(8, 1'b0, 8'h00);
    repeat (20) cycle();
    check("bp_gets", gets_total - g0, DEPTH);
    check("bp_req_released", req_s, 0);
    check("bp_valid", valid_s, 1);
    check("bp_head", data_s, 8'h00);
    ready_mode = 1;
    drain("bp_drain", 80);
    check("bp_gets_total", gets_total - g0, 8);
    check("bp_accepted", accepted - a0, 8);

    // Grant held off: request must stay up with no reads until granted.
    clear_marks();
    gdelay = 6;
    load(3, 1'b1, 8'h00);
    drain("gd_drain", 80);
    check("gd_latency", first_get_cyc - first_req_cyc, 7);
    check("gd_req_held", req_dropped, 0);

    // Reset in the middle of a burst.
    clear_marks();
    gdelay = 1; ready_mode = 1;
    g0 = gets_total;
    load(6, 1'b0, 8'h10);
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      cycle();
      if (gets_total - g0 == 2) reached = 1'b1;
    end
    check("mid_reached", gets_total - g0, 2);
    reset = 1'b0;
    #1;
    check("mid_rst_req", out_ep_req, 0);
    check("mid_rst_get", out_ep_data_get, 0);
    check("mid_rst_valid", uart_out_valid, 0);
    check("mid_rst_stall", out_ep_stall, 0);
    ep_q.delete();
    land_q.delete();
    out_ep_data_avail = 1'b0;
    out_ep_grant = 1'b0;
    gcnt = 0;
    repeat (2) cycle();
    reset = 1'b1;
    clear_marks();
    a0 = accepted;
    load(3, 1'b0, 8'hA0);
    drain("post_rst_drain", 60);
    check("post_rst_accepted", accepted - a0, 3);

    // Randomized bursts with random grant latency and downstream stalls.
    for (int k = 0; k < 12; k++) begin
      clear_marks();
      gdelay = $urandom_range(1, 4);
      ready_mode = $urandom_range(1, 2);
      a0 = accepted;
      g0 = $urandom_range(1, 12);
      load(g0, 1'b1, 8'h00);
      drain("rand_drain", 400);
      check("rand_accepted", accepted - a0, g0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d of %0d checks)", errors, checks);
    $fatal(1);
  end

endmodule
